axis_spi_burst_ctrl: RTL and testbench

Transaction sequencer that sits directly upstream of `axis_spi_master`. It accepts one command (slave address, write length, read length) and streams the write bytes from a TX AXI-Stream into the master's `s_axis`. It then inserts dummy bytes for the read phase, discards the bytes the master returns during the write phase, and forwards the read-phase bytes to an RX AXI-Stream with `tlast` on the final byte. It drives the master's `addr_i` for the duration of each transaction.

---
 rtl/axis_spi_burst_ctrl_if.sv | 56 +++++
 rtl/axis_spi_burst_ctrl.sv | 144 ++++++++++++++
 tb/tb_axis_spi_burst_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_spi_burst_ctrl_if.sv
// Stream and command bundle around the SPI burst sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface axis_spi_burst_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 1,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [AW-1:0]         cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_wr_len_i;
  logic [LEN_WIDTH-1:0]  cmd_rd_len_i;

  logic [DATA_WIDTH-1:0] s_tx_tdata;
  logic                  s_tx_tvalid;
  logic                  s_tx_tready;

  logic [DATA_WIDTH-1:0] m_spi_tdata;
  logic                  m_spi_tvalid;
  logic                  m_spi_tready;

  logic [DATA_WIDTH-1:0] s_spi_tdata;
  logic                  s_spi_tvalid;
  logic                  s_spi_tready;

  logic [DATA_WIDTH-1:0] m_rx_tdata;
  logic                  m_rx_tvalid;
  logic                  m_rx_tready;
  logic                  m_rx_tlast;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_wr_len_i, cmd_rd_len_i,
    output cmd_ready_o,
    input  s_tx_tdata, s_tx_tvalid,
    output s_tx_tready,
    output m_spi_tdata, m_spi_tvalid,
    input  m_spi_tready,
    input  s_spi_tdata, s_spi_tvalid,
    output s_spi_tready,
    output m_rx_tdata, m_rx_tvalid, m_rx_tlast,
    input  m_rx_tready
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_wr_len_i, cmd_rd_len_i,
    input  cmd_ready_o,
    output s_tx_tdata, s_tx_tvalid,
    input  s_tx_tready,
    input  m_spi_tdata, m_spi_tvalid,
    output m_spi_tready,
    output s_spi_tdata, s_spi_tvalid,
    input  s_spi_tready,
    input  m_rx_tdata, m_rx_tvalid, m_rx_tlast,
    output m_rx_tready
  );
endinterface

// File: rtl/axis_spi_burst_ctrl.sv
// Sequences one SPI burst: write bytes from the TX stream, dummy bytes for the
// read phase, discards write-phase echoes and forwards read-phase bytes to RX.
module axis_spi_burst_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SLAVE_NUM  = 1,
  parameter int                    LEN_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DUMMY_BYTE = 8'hFF,
  localparam int                   AW         = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  axis_spi_burst_ctrl_if.slave        bus,
  output logic [AW-1:0]               addr_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int             CW  = LEN_WIDTH + 1;
  localparam logic [CW-1:0]  ONE = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [CW-1:0]  ZERO = {CW{1'b0}};

  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [CW-1:0]   wr_len_r;
  logic [CW-1:0]   total_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [CW-1:0]   rx_cnt_r;
  logic [AW-1:0]   addr_r;
  logic            done_r;

  logic [CW-1:0]   cmd_total_s;
  logic            idle_s;
  logic            cmd_hs_s;
  logic            slot_s;
  logic            wr_phase_s;
  logic            fwd_s;
  logic            spi_tvalid_s;
  logic            spi_hs_s;
  logic            ret_tready_s;
  logic            ret_hs_s;
  logic            last_ret_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign cmd_total_s = {1'b0, bus.cmd_wr_len_i} + {1'b0, bus.cmd_rd_len_i};
  assign cmd_hs_s    = idle_s & bus.cmd_valid_i;
  // One byte in flight: issue only once the previous byte has come back.
  assign slot_s      = ~idle_s & (tx_cnt_r == rx_cnt_r) & (tx_cnt_r < total_r);
  // IDLE selects the write path so the MOSI mux rests on the TX data.
  assign wr_phase_s  = idle_s | (tx_cnt_r < wr_len_r);
  assign fwd_s       = ~idle_s & (rx_cnt_r >= wr_len_r);
  assign spi_tvalid_s = wr_phase_s ? (bus.s_tx_tvalid & slot_s) : slot_s;
  assign spi_hs_s    = spi_tvalid_s & bus.m_spi_tready;
  assign ret_tready_s = fwd_s ? bus.m_rx_tready : 1'b1;
  assign ret_hs_s    = ~idle_s & bus.s_spi_tvalid & ret_tready_s;
  assign last_ret_s  = (rx_cnt_r == (total_r - ONE));

  // State register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; zero-length commands never leave IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s && (cmd_total_s != ZERO)) begin
          state_nx_s = ST_XFER;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (ret_hs_s && last_ret_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_XFER;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Command latch, byte counters and the completion pulse.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_len_r <= ZERO;
      total_r  <= ZERO;
      tx_cnt_r <= ZERO;
      rx_cnt_r <= ZERO;
      addr_r   <= {AW{1'b0}};
      done_r   <= 1'b0;
    end else begin
      if (cmd_hs_s) begin
        wr_len_r <= {1'b0, bus.cmd_wr_len_i};
        total_r  <= cmd_total_s;
        addr_r   <= bus.cmd_addr_i;
        tx_cnt_r <= ZERO;
        rx_cnt_r <= ZERO;
      end else begin
        if (spi_hs_s) begin
          tx_cnt_r <= tx_cnt_r + ONE;
        end
        if (ret_hs_s) begin
          rx_cnt_r <= rx_cnt_r + ONE;
        end
      end
      done_r <= (cmd_hs_s & (cmd_total_s == ZERO)) | (ret_hs_s & last_ret_s);
    end
  end

  // Stream outputs: pure combinational steering, no data storage.
  always_comb begin
    bus.cmd_ready_o  = idle_s;
    bus.m_spi_tvalid = spi_tvalid_s;
    bus.m_rx_tdata   = bus.s_spi_tdata;
    bus.s_spi_tready = ret_tready_s;
    if (wr_phase_s) begin
      bus.m_spi_tdata = bus.s_tx_tdata;
      bus.s_tx_tready = bus.m_spi_tready & slot_s;
    end else begin
      bus.m_spi_tdata = DUMMY_BYTE;
      bus.s_tx_tready = 1'b0;
    end
    if (fwd_s) begin
      bus.m_rx_tvalid = bus.s_spi_tvalid;
      bus.m_rx_tlast  = last_ret_s;
    end else begin
      bus.m_rx_tvalid = 1'b0;
      bus.m_rx_tlast  = 1'b0;
    end
  end

  assign addr_o = addr_r;
  assign busy_o = ~idle_s;
  assign done_o = done_r;

endmodule

// File: tb/tb_axis_spi_burst_ctrl.sv
// Directed loopback bench: a behavioural SPI master echoes each MOSI byte back
// as MISO a few cycles later, and the sequencer's ordering is checked.
module tb_axis_spi_burst_ctrl;
  localparam int DW = 8;
  localparam int SN = 4;
  localparam int AW = 2;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  axis_spi_burst_ctrl_if #(.DATA_WIDTH(DW), .AW(AW), .LEN_WIDTH(LW)) bus ();
  logic [AW-1:0] addr_o;
  logic          busy_o;
  logic          done_o;

  axis_spi_burst_ctrl #(.DATA_WIDTH(DW), .SLAVE_NUM(SN), .LEN_WIDTH(LW), .DUMMY_BYTE(8'hFF)) dut (
    .clk_i(clk), .arstn_i(arstn), .bus(bus), .addr_o(addr_o), .busy_o(busy_o), .done_o(done_o)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] mosi_log[$];
  logic [7:0] pend_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] tx_src_q[$];
  bit         tlast_log[$];
  int done_cnt = 0, outstanding = 0, max_out = 0, rx_stab_err = 0, done_busy_err = 0;
  int spi_tvalid_cnt = 0, rxv_cnt = 0, lat = 0, bp_cnt = 0;
  bit tx_hs_seen = 1'b0, ret_hs_seen = 1'b0, gaps_en = 1'b0, bp_en = 1'b0;
  bit prev_rxv = 1'b0, prev_rxr = 1'b0;
  logic [7:0] prev_rxd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hXX;
  endfunction

  // Posedge monitor: records every handshake using pre-edge values.
  always @(posedge clk) begin
    tx_hs_seen = bus.s_tx_tvalid && bus.s_tx_tready;
    if (tx_hs_seen && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
    if (bus.m_spi_tvalid) spi_tvalid_cnt++;
    if (bus.m_rx_tvalid) rxv_cnt++;
    if (bus.m_spi_tvalid && bus.m_spi_tready) begin
      mosi_log.push_back(bus.m_spi_tdata);
      pend_q.push_back(bus.m_spi_tdata);
      outstanding++;
    end
    ret_hs_seen = bus.s_spi_tvalid && bus.s_spi_tready;
    if (ret_hs_seen) begin
      if (pend_q.size() > 0) void'(pend_q.pop_front());
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (bus.m_rx_tvalid && bus.m_rx_tready) begin
      rx_log.push_back(bus.m_rx_tdata);
      tlast_log.push_back(bus.m_rx_tlast);
    end
    if (arstn && prev_rxv && !prev_rxr && (!bus.m_rx_tvalid || bus.m_rx_tdata !== prev_rxd)) rx_stab_err++;
    prev_rxv = bus.m_rx_tvalid;
    prev_rxr = bus.m_rx_tready;
    prev_rxd = bus.m_rx_tdata;
    if (done_o) begin
      done_cnt++;
      if (busy_o) done_busy_err++;
    end
  end

  // Negedge drivers: SPI master echo model, TX source, RX sink.
  initial forever begin
    @(negedge clk);
    if (bus.s_spi_tvalid) begin
      if (ret_hs_seen) begin
        bus.s_spi_tvalid = 1'b0;
        lat = 0;
      end
    end else if (pend_q.size() > 0) begin
      lat++;
      if (lat >= 3) begin
        bus.s_spi_tdata  = pend_q[0];
        bus.s_spi_tvalid = 1'b1;
      end
    end
    if (tx_src_q.size() == 0) begin
      bus.s_tx_tvalid = 1'b0;
    end else if (!(bus.s_tx_tvalid && !tx_hs_seen)) begin
      bus.s_tx_tvalid = gaps_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    bus.s_tx_tdata = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    if (!bp_en) begin
      bus.m_rx_tready = 1'b1;
    end else if (bus.m_rx_tready) begin
      bus.m_rx_tready = 1'b0;
      bp_cnt = 0;
    end else if (bus.m_rx_tvalid) begin
      bp_cnt++;
      if (bp_cnt >= 20) bus.m_rx_tready = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    mosi_log.delete();
    rx_log.delete();
    tlast_log.delete();
    max_out = outstanding;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input int wr, input int rd);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_addr_i   = a;
    bus.cmd_wr_len_i = wr[7:0];
    bus.cmd_rd_len_i = rd[7:0];
    bus.cmd_valid_i  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    check("cmd_accept", ok, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int start, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_cnt > start) break;
    end
    check(tag, (done_cnt > start), 1'b1);
  endtask

  initial begin
    int d0, s0;
    logic [7:0] exp_b[10];
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_wr_len_i = 8'h00; bus.cmd_rd_len_i = 8'h00;
    bus.s_tx_tvalid = 1'b0; bus.s_tx_tdata = 8'h00; bus.m_spi_tready = 1'b1;
    bus.s_spi_tvalid = 1'b0; bus.s_spi_tdata = 8'h00; bus.m_rx_tready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_addr", addr_o, 2'd0);
    check("rst_spi_tvalid", bus.m_spi_tvalid, 1'b0);
    check("rst_s_spi_tready", bus.s_spi_tready, 1'b1);
    check("rst_rx_tvalid", bus.m_rx_tvalid, 1'b0);
    @(negedge clk);
    arstn = 1'b1;

    // Write-only, addr 0: A5,3C,0F
    clear_logs(); d0 = done_cnt; s0 = rxv_cnt;
    tx_src_q.push_back(8'hA5); tx_src_q.push_back(8'h3C); tx_src_q.push_back(8'h0F);
    send_cmd(2'd0, 3, 0);
    #1 check("wo_busy", busy_o, 1'b1);
    wait_done("wo_done", d0, 200);
    repeat (3) @(negedge clk);
    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h0F;
    check("wo_mosi_cnt", mosi_log.size(), 3);
    for (int i = 0; i < 3; i++) check("wo_mosi", qat(mosi_log, i), exp_b[i]);
    check("wo_no_rx", rxv_cnt - s0, 0);
    check("wo_done_once", done_cnt - d0, 1);
    check("wo_done_busy", done_busy_err, 0);

    // Write-then-read at addr 2: 9F then three dummy bytes
    clear_logs(); d0 = done_cnt;
    tx_src_q.push_back(8'h9F);
    send_cmd(2'd2, 1, 3);
    #1 check("wr_addr_busy", addr_o, 2'd2);
    wait_done("wr_done", d0, 300);
    repeat (3) @(negedge clk);
    exp_b[0] = 8'h9F; exp_b[1] = 8'hFF; exp_b[2] = 8'hFF; exp_b[3] = 8'hFF;
    check("wr_mosi_cnt", mosi_log.size(), 4);
    for (int i = 0; i < 4; i++) check("wr_mosi", qat(mosi_log, i), exp_b[i]);
    check("wr_rx_cnt", rx_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("wr_rx_data", qat(rx_log, i), 8'hFF);
      check("wr_rx_tlast", (i < tlast_log.size()) ? tlast_log[i] : 1'bx, (i == 2) ? 1'b1 : 1'b0);
    end
    check("wr_addr_held", addr_o, 2'd2);

    // Zero-length command
    d0 = done_cnt; s0 = spi_tvalid_cnt;
    send_cmd(2'd1, 0, 0);
    #1;
    check("zl_done_n1", done_o, 1'b1);
    check("zl_busy", busy_o, 1'b0);
    check("zl_cmd_ready", bus.cmd_ready_o, 1'b1);
    @(negedge clk); #1;
    check("zl_done_clear", done_o, 1'b0);
    check("zl_cmd_ready2", bus.cmd_ready_o, 1'b1);
    repeat (3) @(negedge clk);
    check("zl_no_spi", spi_tvalid_cnt - s0, 0);

    // RX backpressure: wr=0 rd=4, 20 stall cycles per byte
    clear_logs(); d0 = done_cnt; bp_en = 1'b1;
    send_cmd(2'd3, 0, 4);
    wait_done("bp_done", d0, 600);
    bp_en = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_rx_cnt", rx_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("bp_rx_data", qat(rx_log, i), 8'hFF);
      check("bp_rx_tlast", (i < tlast_log.size()) ? tlast_log[i] : 1'bx, (i == 3) ? 1'b1 : 1'b0);
    end
    check("bp_outstanding", (max_out <= 1), 1'b1);
    check("bp_rx_stable", rx_stab_err, 0);

    // Reset during the second byte of a wr=4 command
    clear_logs(); d0 = done_cnt;
    tx_src_q.push_back(8'h11); tx_src_q.push_back(8'h22); tx_src_q.push_back(8'h33); tx_src_q.push_back(8'h44);
    send_cmd(2'd1, 4, 0);
    for (int i = 0; i < 100; i++) begin
      if (mosi_log.size() >= 2) break;
      @(negedge clk);
    end
    check("rr_second_byte", (mosi_log.size() >= 2), 1'b1);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    check("rr_cmd_ready", bus.cmd_ready_o, 1'b1);
    check("rr_busy", busy_o, 1'b0);
    check("rr_done", done_o, 1'b0);
    check("rr_addr", addr_o, 2'd0);
    check("rr_spi_tvalid", bus.m_spi_tvalid, 1'b0);
    check("rr_spi_tdata", bus.m_spi_tdata, bus.s_tx_tdata);
    check("rr_tx_tready", bus.s_tx_tready, 1'b0);
    check("rr_s_spi_tready", bus.s_spi_tready, 1'b1);
    check("rr_rx_tvalid", bus.m_rx_tvalid, 1'b0);
    check("rr_rx_tlast", bus.m_rx_tlast, 1'b0);
    tx_src_q.delete();
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (pend_q.size() == 0 && !bus.s_spi_tvalid) break;
      @(negedge clk);
    end
    check("rr_drain", pend_q.size(), 0);
    check("rr_no_done", done_cnt - d0, 0);
    check("rr_no_rx", rx_log.size(), 0);
    clear_logs(); d0 = done_cnt;
    tx_src_q.push_back(8'h55);
    send_cmd(2'd0, 1, 0);
    wait_done("rr_next_done", d0, 200);
    repeat (3) @(negedge clk);
    check("rr_next_cnt", mosi_log.size(), 1);
    check("rr_next_mosi", qat(mosi_log, 0), 8'h55);
    check("rr_next_done_once", done_cnt - d0, 1);

    // TX starvation with random gaps: wr=8 (00..07), rd=2
    clear_logs(); d0 = done_cnt; gaps_en = 1'b1;
    for (int i = 0; i < 8; i++) tx_src_q.push_back(i[7:0]);
    send_cmd(2'd2, 8, 2);
    wait_done("st_done", d0, 1000);
    gaps_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) exp_b[i] = (i < 8) ? i[7:0] : 8'hFF;
    check("st_mosi_cnt", mosi_log.size(), 10);
    for (int i = 0; i < 10; i++) check("st_mosi", qat(mosi_log, i), exp_b[i]);
    check("st_rx_cnt", rx_log.size(), 2);
    check("st_rx_data0", qat(rx_log, 0), 8'hFF);
    check("st_rx_data1", qat(rx_log, 1), 8'hFF);
    check("st_tlast0", (tlast_log.size() > 0) ? tlast_log[0] : 1'bx, 1'b0);
    check("st_tlast1", (tlast_log.size() > 1) ? tlast_log[1] : 1'bx, 1'b1);
    check("st_outstanding", (max_out <= 1), 1'b1);
    check("st_done_busy", done_busy_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
